// File: rtl/ysyx_23060201_dmem_pkg.sv
// rtl/ysyx_23060201_dmem_pkg.sv - shared mask encodings, sign-select bit and FSM states for the data memory
package ysyx_23060201_dmem_pkg;

    // Size masks carried in bits [3:0] of the store / load mask fields.
    localparam logic [3:0] ysyx_23060201_MASK_B = 4'b0001;
    localparam logic [3:0] ysyx_23060201_MASK_H = 4'b0011;
    localparam logic [3:0] ysyx_23060201_MASK_W = 4'b1111;

    // Bit of the load mask that requests sign extension.
    localparam int ysyx_23060201_SIGN_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    function automatic logic mask_legal(input logic [3:0] m);
        return (m == ysyx_23060201_MASK_B) || (m == ysyx_23060201_MASK_H) ||
               (m == ysyx_23060201_MASK_W);
    endfunction

endpackage

// File: rtl/ysyx_23060201_dmem_align.sv
// rtl/ysyx_23060201_dmem_align.sv - combinational legality check, word index and load align/extend
//
// Ports:
//   i_wen, i_ren     request kind (exactly one must be set)
//   i_addr           byte address
//   i_wmask[3:0]     store size mask
//   i_rmask[4:0]     load size mask, bit 4 = sign extend
//   i_word           array word addressed by o_idx
//   o_err            request is illegal
//   o_idx            word index (addr-BASE)>>2
//   o_rdata          aligned/extended load result, 0 for stores and errors
module ysyx_23060201_dmem_align
    import ysyx_23060201_dmem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE       = 32'h8000_0000,
    parameter int                    DEPTH      = 4096,
    parameter int                    IDX_W      = 12
) (
    input  logic                  i_wen,
    input  logic                  i_ren,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [3:0]            i_wmask,
    input  logic [4:0]            i_rmask,
    input  logic [DATA_WIDTH-1:0] i_word,
    output logic                  o_err,
    output logic [IDX_W-1:0]      o_idx,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    // One bit wider than the address so BASE+4*DEPTH cannot wrap.
    localparam logic [ADDR_WIDTH:0] P_LIMIT = {1'b0, BASE} + (ADDR_WIDTH+1)'(4 * DEPTH);

    logic [3:0]            w_size;
    logic                  w_in_range;
    logic                  w_misalign;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic [DATA_WIDTH-1:0] w_raw;
    logic                  w_sign;

    always_comb begin
        w_size     = i_wen ? i_wmask : i_rmask[3:0];
        w_in_range = (i_addr >= BASE) && ({1'b0, i_addr} < P_LIMIT);
        w_misalign = ((w_size == ysyx_23060201_MASK_H) && i_addr[0]) ||
                     ((w_size == ysyx_23060201_MASK_W) && (i_addr[1:0] != 2'b00));
        o_err      = (i_wen == i_ren) || !w_in_range || !mask_legal(w_size) || w_misalign;

        w_offset   = i_addr - BASE;
        o_idx      = w_offset[IDX_W+1:2];

        w_raw      = i_word >> {i_addr[1:0], 3'b000};
        w_sign     = i_rmask[ysyx_23060201_SIGN_BIT];

        case (i_rmask[3:0])
            ysyx_23060201_MASK_B:
                o_rdata = {{(DATA_WIDTH-8){w_sign & w_raw[7]}}, w_raw[7:0]};
            ysyx_23060201_MASK_H:
                o_rdata = {{(DATA_WIDTH-16){w_sign & w_raw[15]}}, w_raw[15:0]};
            default:
                o_rdata = w_raw;
        endcase

        if (o_err || !i_ren) begin
            o_rdata = '0;
        end
    end

endmodule

// File: rtl/ysyx_23060201_dmem.sv
// rtl/ysyx_23060201_dmem.sv - multi-cycle data memory responder with valid/ready request and response
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_wen/req_ren                store / load select
//   req_addr                       byte address
//   req_wmask, req_wdata           store size mask and right-aligned data
//   req_rmask                      load size mask, bit 4 = sign extend
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata, rsp_err             load result and illegal-request flag
module ysyx_23060201_dmem
    import ysyx_23060201_dmem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE       = 32'h8000_0000,
    parameter int                    DEPTH      = 4096,
    parameter int                    LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic                  req_ren,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_wmask,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [7:0]            req_rmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    dmem_state_e           r_state;
    dmem_state_e           w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;

    logic                  r_wen;
    logic                  r_ren;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_wmask;
    logic [4:0]            r_rmask;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_exec;
    logic                  w_err;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata_sh;

    ysyx_23060201_dmem_align #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BASE       (BASE),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_align (
        .i_wen   (r_wen),
        .i_ren   (r_ren),
        .i_addr  (r_addr),
        .i_wmask (r_wmask),
        .i_rmask (r_rmask),
        .i_word  (r_mem[w_idx]),
        .o_err   (w_err),
        .o_idx   (w_idx),
        .o_rdata (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_exec      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_exec      = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // Request fields are captured once at acceptance; the inputs are free to change afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_wen       <= 1'b0;
            r_ren       <= 1'b0;
            r_addr      <= '0;
            r_wmask     <= '0;
            r_rmask     <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wen   <= req_wen;
                r_ren   <= req_ren;
                r_addr  <= req_addr;
                r_wmask <= req_wmask[3:0];
                r_rmask <= req_rmask[4:0];
                r_wdata <= req_wdata;
                r_cnt   <= CNT_LOAD;
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_exec) begin
                r_rsp_rdata <= w_load_data;
                r_rsp_err   <= w_err;
            end
        end
    end

    assign w_be       = r_wmask << r_addr[1:0];
    assign w_wdata_sh = r_wdata << {r_addr[1:0], 3'b000};

    // Array has no reset; a reset on the execute edge suppresses the write so the store is lost.
    always_ff @(posedge clk) begin
        if (w_exec && r_wen && !w_err && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060201_dmem.sv
// tb/tb_ysyx_23060201_dmem.sv - directed self-checking bench for ysyx_23060201_dmem
module tb_ysyx_23060201_dmem;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic        req_ren;
    logic [31:0] req_addr;
    logic [7:0]  req_wmask;
    logic [31:0] req_wdata;
    logic [7:0]  req_rmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_23060201_dmem dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_ren   (req_ren),
        .req_addr  (req_addr),
        .req_wmask (req_wmask),
        .req_wdata (req_wdata),
        .req_rmask (req_rmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction; hold>0 keeps rsp_ready low for that many extra cycles.
    task automatic txn(input string tag, input logic wen, input logic ren,
                       input logic [31:0] addr, input logic [7:0] wm, input logic [7:0] rm,
                       input logic [31:0] wd, input logic [31:0] exp_rdata,
                       input logic exp_err, input int hold);
        int lat;
        @(negedge clk);
        check({tag, "/req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_wen   = wen;
        req_ren   = ren;
        req_addr  = addr;
        req_wmask = wm;
        req_rmask = rm;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wen   = 1'($urandom);
        req_ren   = 1'($urandom);
        req_addr  = $urandom;
        req_wmask = 8'($urandom);
        req_rmask = 8'($urandom);
        req_wdata = $urandom;
        @(negedge clk);
        check({tag, "/req_ready_wait"}, 32'(req_ready), 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "/latency"}, 32'(lat), 32'd2);
        check({tag, "/rdata"}, rsp_rdata, exp_rdata);
        check({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "/hold_rdata"}, rsp_rdata, exp_rdata);
            check({tag, "/hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "/post_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "/post_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_ren   = 1'b0;
        req_addr  = '0;
        req_wmask = '0;
        req_rmask = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset/req_ready", 32'(req_ready), 32'd1);
        check("reset/rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset/rsp_rdata", rsp_rdata, 32'd0);
        check("reset/rsp_err", 32'(rsp_err), 32'd0);

        // Known background values.
        txn("st_w0",   1, 0, 32'h8000_0000, 8'h0F, 8'h00, 32'h1122_3344, 32'h0, 0, 0);
        txn("st_w20",  1, 0, 32'h8000_0020, 8'h0F, 8'h00, 32'h0000_0000, 32'h0, 0, 0);

        txn("st_dead", 1, 0, 32'h8000_0010, 8'h0F, 8'h00, 32'hDEAD_BEEF, 32'h0, 0, 0);
        txn("ld_dead", 0, 1, 32'h8000_0010, 8'h00, 8'h0F, 32'h0, 32'hDEAD_BEEF, 0, 0);

        txn("st_b13",  1, 0, 32'h8000_0013, 8'hF1, 8'h00, 32'hAAAA_AA80, 32'h0, 0, 0);
        txn("ld_w10",  0, 1, 32'h8000_0010, 8'h00, 8'h0F, 32'h0, 32'h80AD_BEEF, 0, 0);
        txn("lb_s13",  0, 1, 32'h8000_0013, 8'h00, 8'h11, 32'h0, 32'hFFFF_FF80, 0, 0);
        txn("lb_u13",  0, 1, 32'h8000_0013, 8'h00, 8'h01, 32'h0, 32'h0000_0080, 0, 0);
        txn("lh_s12",  0, 1, 32'h8000_0012, 8'h00, 8'h13, 32'h0, 32'hFFFF_80AD, 0, 0);
        txn("lh_s11",  0, 1, 32'h8000_0011, 8'h00, 8'h13, 32'h0, 32'h0, 1, 0);
        txn("lh_u10",  0, 1, 32'h8000_0010, 8'h00, 8'h03, 32'h0, 32'h0000_BEEF, 0, 0);
        txn("lh_s10",  0, 1, 32'h8000_0010, 8'h00, 8'h13, 32'h0, 32'hFFFF_BEEF, 0, 0);
        txn("lb_s11",  0, 1, 32'h8000_0011, 8'h00, 8'h11, 32'h0, 32'hFFFF_FFBE, 0, 0);

        // Illegal requests.
        txn("st_low",  1, 0, 32'h7FFF_FFFC, 8'h0F, 8'h00, 32'h5555_5555, 32'h0, 1, 0);
        txn("st_high", 1, 0, 32'h8000_4000, 8'h0F, 8'h00, 32'h6666_6666, 32'h0, 1, 0);
        txn("both",    1, 1, 32'h8000_0000, 8'h0F, 8'h0F, 32'h7777_7777, 32'h0, 1, 0);
        txn("neither", 0, 0, 32'h8000_0000, 8'h0F, 8'h0F, 32'h0, 32'h0, 1, 0);
        txn("bad_msk", 1, 0, 32'h8000_0000, 8'h07, 8'h00, 32'h8888_8888, 32'h0, 1, 0);
        txn("st_w_mis",1, 0, 32'h8000_0002, 8'h0F, 8'h00, 32'h9999_9999, 32'h0, 1, 0);
        txn("ld_w0",   0, 1, 32'h8000_0000, 8'h00, 8'h0F, 32'h0, 32'h1122_3344, 0, 0);

        // Last legal word.
        txn("st_last", 1, 0, 32'h8000_3FFC, 8'h0F, 8'h00, 32'hCAFE_F00D, 32'h0, 0, 0);
        txn("ld_last", 0, 1, 32'h8000_3FFC, 8'h00, 8'h0F, 32'h0, 32'hCAFE_F00D, 0, 0);

        // Back-pressure on the response.
        txn("hold",    0, 1, 32'h8000_0010, 8'h00, 8'h0F, 32'h0, 32'h80AD_BEEF, 0, 5);

        // Reset while a store is waiting: the store must be dropped.
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_ren   = 1'b0;
        req_addr  = 32'h8000_0020;
        req_wmask = 8'h0F;
        req_rmask = 8'h00;
        req_wdata = 32'h5A5A_5A5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rstw/in_wait", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstw/req_ready", 32'(req_ready), 32'd1);
        check("rstw/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstw/rsp_rdata", rsp_rdata, 32'd0);
        check("rstw/rsp_err", 32'(rsp_err), 32'd0);
        repeat (3) @(negedge clk);
        check("rstw/no_rsp", 32'(rsp_valid), 32'd0);
        txn("ld_w20",  0, 1, 32'h8000_0020, 8'h00, 8'h0F, 32'h0, 32'h0, 0, 0);

        // Half store and a misaligned half store that must not write.
        txn("sh_12",   1, 0, 32'h8000_0012, 8'h03, 8'h00, 32'hFFFF_5566, 32'h0, 0, 0);
        txn("sh_11",   1, 0, 32'h8000_0011, 8'h03, 8'h00, 32'h0000_1234, 32'h0, 1, 0);
        txn("ld_sh",   0, 1, 32'h8000_0010, 8'h00, 8'h0F, 32'h0, 32'h5566_BEEF, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
